button_set_controller: RTL and testbench

BUTTON_SET_CONTROLLER -- requirements
Module: button_set_controller

---
 rtl/clock_pkg.sv | 24 ++
 rtl/auto_repeat.sv | 61 ++++++
 rtl/button_set_controller.sv | 143 ++++++++++++++
 tb/tb_button_set_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared mode encodings, field limits and the wrap-around step helper for the
// clock set controller.
package clock_pkg;

    typedef enum logic [1:0] {
        ModeRun    = 2'd0,
        ModeSetHr  = 2'd1,
        ModeSetMin = 2'd2
    } mode_e;

    localparam logic [5:0] HOUR_MAX = 6'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] SEC_MAX  = 6'd59;

    // One step up or down within 0..max, wrapping at both ends.
    function automatic logic [5:0] wrap_step(input logic [5:0] val, input logic [5:0] max,
                                             input logic up);
        if (up) begin
            return (val == max) ? 6'd0 : val + 6'd1;
        end
        return (val == 6'd0) ? max : val - 6'd1;
    endfunction

endpackage

// File: rtl/auto_repeat.sv
// Hold counter shared by the inc/dec buttons; emits one-clk up/down step pulses
// from press pulses and from auto-repeat while a single button is held.
module auto_repeat #(
    parameter int unsigned REPEAT_DELAY = 500,
    parameter int unsigned REPEAT_RATE  = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_inc_down,
    input  logic i_dec_down,
    input  logic i_inc_state,
    input  logic i_dec_state,
    output logic o_step_up,
    output logic o_step_dn
);

    localparam int unsigned HW = $clog2(REPEAT_DELAY + 1);
    localparam int unsigned RW = (REPEAT_RATE > 1) ? $clog2(REPEAT_RATE) : 1;
    localparam logic [HW-1:0] DELAY_V = HW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RATE_M1 = RW'(REPEAT_RATE - 1);

    logic [HW-1:0] r_hold_cnt;
    logic [RW-1:0] r_rate_cnt;
    logic          w_held;
    logic          w_both;
    logic          w_at_delay;
    logic          w_delay_hit;
    logic          w_rate_hit;
    logic          w_repeat;

    assign w_held      = i_inc_state | i_dec_state;
    assign w_both      = i_inc_state & i_dec_state;
    assign w_at_delay  = (r_hold_cnt == DELAY_V);
    assign w_delay_hit = i_tick & w_held & (r_hold_cnt == DELAY_V - 1'b1);
    assign w_rate_hit  = i_tick & w_held & w_at_delay & (r_rate_cnt == RATE_M1);
    assign w_repeat    = (w_delay_hit | w_rate_hit) & ~w_both;

    assign o_step_up = i_inc_down | (w_repeat & i_inc_state);
    assign o_step_dn = i_dec_down | (w_repeat & i_dec_state);

    // Hold counter parks at REPEAT_DELAY; the rate counter then paces repeats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
            r_rate_cnt <= '0;
        end else if (!w_held) begin
            r_hold_cnt <= '0;
            r_rate_cnt <= '0;
        end else if (i_tick) begin
            if (!w_at_delay) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end else if (w_rate_hit) begin
                r_rate_cnt <= '0;
            end else begin
                r_rate_cnt <= r_rate_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_set_controller.sv
// Clock time-of-day keeper with a three-button set interface: mode cycling,
// hour/minute stepping with auto-repeat, idle timeout and field blink.
module button_set_controller
    import clock_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 500,
    parameter int unsigned REPEAT_RATE  = 100,
    parameter int unsigned IDLE_TIMEOUT = 10000,
    parameter int unsigned BLINK_HALF   = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       sec_tick,
    input  logic       mode_down,
    input  logic       inc_down,
    input  logic       dec_down,
    input  logic       inc_state,
    input  logic       dec_state,
    output logic [1:0] mode,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       blink
);

    localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [IW-1:0] IDLE_V   = IW'(IDLE_TIMEOUT);
    localparam logic [BW-1:0] BLINK_M1 = BW'(BLINK_HALF - 1);

    mode_e         r_mode;
    logic [4:0]    r_hours;
    logic [5:0]    r_minutes;
    logic [5:0]    r_seconds;
    logic          r_blink;
    logic [IW-1:0] r_idle_cnt;
    logic [BW-1:0] r_blink_cnt;

    logic          w_step_up;
    logic          w_step_dn;
    logic          w_set;
    logic          w_any_down;
    logic          w_timeout;
    logic          w_mode_chg;
    logic          w_up;
    logic          w_step;
    logic [IW-1:0] w_idle_nxt;

    auto_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_auto_repeat (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_tick      (tick),
        .i_inc_down  (inc_down),
        .i_dec_down  (dec_down),
        .i_inc_state (inc_state),
        .i_dec_state (dec_state),
        .o_step_up   (w_step_up),
        .o_step_dn   (w_step_dn)
    );

    assign w_set      = (r_mode != ModeRun);
    assign w_any_down = mode_down | inc_down | dec_down;
    assign w_idle_nxt = (r_idle_cnt == IDLE_V) ? r_idle_cnt : r_idle_cnt + 1'b1;
    assign w_timeout  = w_set & tick & ~w_any_down & (w_idle_nxt == IDLE_V);
    assign w_mode_chg = mode_down | w_timeout;
    // Opposing steps cancel; a mode press swallows any step in the same cycle.
    assign w_up       = w_step_up & ~w_step_dn;
    assign w_step     = w_set & ~mode_down & (w_step_up ^ w_step_dn);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= ModeRun;
            r_hours     <= '0;
            r_minutes   <= '0;
            r_seconds   <= '0;
            r_blink     <= 1'b0;
            r_idle_cnt  <= '0;
            r_blink_cnt <= '0;
        end else begin
            if (mode_down) begin
                case (r_mode)
                    ModeRun:   r_mode <= ModeSetHr;
                    ModeSetHr: r_mode <= ModeSetMin;
                    default:   r_mode <= ModeRun;
                endcase
            end else if (w_timeout) begin
                r_mode <= ModeRun;
            end

            if (r_mode == ModeRun) begin
                if (mode_down) begin
                    r_seconds <= '0;
                end else if (sec_tick) begin
                    if (r_seconds == SEC_MAX) begin
                        r_seconds <= '0;
                        r_minutes <= wrap_step(r_minutes, MIN_MAX, 1'b1);
                        if (r_minutes == MIN_MAX) begin
                            r_hours <= 5'(wrap_step({1'b0, r_hours}, HOUR_MAX, 1'b1));
                        end
                    end else begin
                        r_seconds <= r_seconds + 6'd1;
                    end
                end
            end else if (w_step) begin
                if (r_mode == ModeSetHr) begin
                    r_hours <= 5'(wrap_step({1'b0, r_hours}, HOUR_MAX, w_up));
                end else begin
                    r_minutes <= wrap_step(r_minutes, MIN_MAX, w_up);
                end
            end

            if (!w_set || w_any_down || w_timeout) begin
                r_idle_cnt <= '0;
            end else if (tick) begin
                r_idle_cnt <= w_idle_nxt;
            end

            // Restarting the phase on a step keeps the field visible while adjusting.
            if (!w_set || w_mode_chg || w_step) begin
                r_blink     <= 1'b0;
                r_blink_cnt <= '0;
            end else if (tick) begin
                if (r_blink_cnt == BLINK_M1) begin
                    r_blink     <= ~r_blink;
                    r_blink_cnt <= '0;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    assign mode    = r_mode;
    assign hours   = r_hours;
    assign minutes = r_minutes;
    assign seconds = r_seconds;
    assign blink   = r_blink;

endmodule

// File: tb/tb_button_set_controller.sv
// Scoreboard bench: directed scenarios plus random stimulus, checked against a
// behavioural clock model working in whole seconds, tick counts and modulo arithmetic.
module tb_button_set_controller;

    localparam int RD = 5;
    localparam int RR = 2;
    localparam int IT = 20;
    localparam int BH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick = 1'b0;
    logic       sec_tick = 1'b0;
    logic       mode_down = 1'b0;
    logic       inc_down = 1'b0;
    logic       dec_down = 1'b0;
    logic       inc_state = 1'b0;
    logic       dec_state = 1'b0;
    logic [1:0] mode;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       blink;

    button_set_controller #(
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .IDLE_TIMEOUT (IT),
        .BLINK_HALF   (BH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .sec_tick  (sec_tick),
        .mode_down (mode_down),
        .inc_down  (inc_down),
        .dec_down  (dec_down),
        .inc_state (inc_state),
        .dec_state (dec_state),
        .mode      (mode),
        .hours     (hours),
        .minutes   (minutes),
        .seconds   (seconds),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    typedef struct {
        int md;
        int hr;
        int mn;
        int sc;
        int bl;
    } exp_t;

    exp_t exp_q[$];
    exp_t rst_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    // Model state: mode number, time fields, ticks held, ticks idle, ticks since blink restart.
    int m_mode, m_h, m_min, m_s, m_hold, m_idle, m_since;

    task automatic model_reset();
        m_mode = 0; m_h = 0; m_min = 0; m_s = 0;
        m_hold = 0; m_idle = 0; m_since = 0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.md = m_mode;
        e.hr = m_h;
        e.mn = m_min;
        e.sc = m_s;
        e.bl = (m_mode != 0) ? (m_since / BH) % 2 : 0;
        return e;
    endfunction

    task automatic model_step(input bit tk, input bit st, input bit md, input bit id,
                              input bit dd, input bit is, input bit ds);
        bit held, rep, up, dn, set, any_down, timeout, step;
        int t, old_mode;
        held = is || ds;
        if (!held) m_hold = 0;
        else if (tk) m_hold++;
        rep = tk && held && !(is && ds) && m_hold >= RD && ((m_hold - RD) % RR == 0);
        up = id || (rep && is);
        dn = dd || (rep && ds);
        old_mode = m_mode;
        set = (old_mode != 0);
        any_down = md || id || dd;
        timeout = set && tk && !any_down && (m_idle + 1 >= IT);
        step = set && !md && (up != dn);

        if (old_mode == 0) begin
            if (md) m_s = 0;
            else if (st) begin
                t = ((m_h * 3600 + m_min * 60 + m_s) + 1) % 86400;
                m_h = t / 3600;
                m_min = (t / 60) % 60;
                m_s = t % 60;
            end
        end else if (step) begin
            if (old_mode == 1) m_h = up ? (m_h + 1) % 24 : (m_h + 23) % 24;
            else m_min = up ? (m_min + 1) % 60 : (m_min + 59) % 60;
        end

        if (md) m_mode = (old_mode + 1) % 3;
        else if (timeout) m_mode = 0;

        if (!set || any_down || timeout) m_idle = 0;
        else if (tk) m_idle = (m_idle + 1 > IT) ? IT : m_idle + 1;

        if (!set || md || timeout || step) m_since = 0;
        else if (tk) m_since++;
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic chk_all(input exp_t e, input string tag);
        chk({tag, " mode"}, int'(mode), e.md);
        chk({tag, " hours"}, int'(hours), e.hr);
        chk({tag, " minutes"}, int'(minutes), e.mn);
        chk({tag, " seconds"}, int'(seconds), e.sc);
        chk({tag, " blink"}, int'(blink), e.bl);
    endtask

    // Outputs are registered, so every clock presents a new result.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) chk_all(exp_q.pop_front(), "cycle");
    end

    always @(negedge rst_n) begin
        #1;
        if (rst_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL reset: no expectation queued at %0t", $time);
        end else begin
            chk_all(rst_q.pop_front(), "reset");
        end
    end

    task automatic cyc(input bit tk, input bit st, input bit md, input bit id,
                       input bit dd, input bit is, input bit ds);
        @(negedge clk);
        tick = tk; sec_tick = st; mode_down = md;
        inc_down = id; dec_down = dd; inc_state = is; dec_state = ds;
        model_step(tk, st, md, id, dd, is, ds);
        exp_q.push_back(model_out());
    endtask

    task automatic do_reset(input bit is, input bit ds);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        tick = 1'b0; sec_tick = 1'b0; mode_down = 1'b0;
        inc_down = 1'b0; dec_down = 1'b0; inc_state = is; dec_state = ds;
        model_reset();
        rst_q.push_back(model_out());
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        bit is_l, ds_l;
        int p;
        model_reset();
        do_reset(1'b0, 1'b0);

        // 60 seconds roll into one minute.
        repeat (60) cyc(0, 1, 0, 0, 0, 0, 0);
        // SET_HR: dec at 0 wraps to 23; SET_MIN: 1->0->59, inc 59->0, dec back to 59.
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        // 23:59:00 -> 23:59:59 -> 00:00:00.
        repeat (60) cyc(0, 1, 0, 0, 0, 0, 0);

        // Auto-repeat in SET_MIN from minutes 10.
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 1, 0, 0, 0);
        repeat (11) cyc(1, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);

        // Idle timeout, then a press at tick 19 restarts the count.
        cyc(0, 0, 1, 0, 0, 0, 0);
        repeat (25) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        repeat (18) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        repeat (22) cyc(1, 0, 0, 0, 0, 0, 0);

        // Mode press beats a step; opposing steps cancel.
        cyc(0, 0, 1, 0, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);

        // Reset mid-hold, then re-enter SET_MIN while still holding.
        repeat (3) cyc(1, 0, 0, 0, 0, 1, 0);
        do_reset(1'b1, 1'b0);
        repeat (2) cyc(1, 0, 0, 0, 0, 1, 0);
        repeat (2) cyc(0, 0, 1, 0, 0, 1, 0);
        repeat (6) cyc(1, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Random phase with varying press density.
        is_l = 1'b0;
        ds_l = 1'b0;
        for (int seg = 0; seg < 4; seg++) begin
            p = (seg == 0) ? 2 : (seg == 1) ? 8 : (seg == 2) ? 20 : 0;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(99) < 3) is_l = !is_l;
                if ($urandom_range(99) < 3) ds_l = !ds_l;
                if ($urandom_range(1999) == 0) do_reset(is_l, ds_l);
                cyc(bit'($urandom_range(1)), $urandom_range(9) == 0,
                    $urandom_range(999) < 15, $urandom_range(99) < p,
                    $urandom_range(99) < p, is_l, ds_l);
            end
        end

        repeat (2) @(negedge clk);
        chk("leftover expectations", exp_q.size() + rst_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
